mbus_wr_arbiter: RTL and testbench

MBUS_WR_ARBITER -- requirements
Module: mbus_wr_arbiter

---
 rtl/mbus_pkg.sv | 24 ++
 rtl/mbus_rr_arbiter.sv | 40 ++++
 rtl/mbus_wr_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mbus_wr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbus_pkg.sv
// -----------------------------------------------------------------------------
// mbus_pkg
// Shared definitions for the MBUS write arbiter:
//   - mbus_state_e : transaction FSM states (idle, address, data, done)
//   - AWLEN_W      : width of the DDR burst-length field
//   - idx_w()      : width of an index into a vector of n requesters
// -----------------------------------------------------------------------------
package mbus_pkg;

    localparam int unsigned AWLEN_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } mbus_state_e;

    // A single requester still needs a one-bit index.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mbus_rr_arbiter
// Combinational round-robin pick. The search starts at i_ptr and wraps
// around, so i_ptr is the highest-priority requester.
// Ports:
//   i_req       in  DEVICE_NUM  request vector
//   i_ptr       in  IW          first index to consider
//   o_grant     out DEVICE_NUM  one-hot grant (all zero when no request)
//   o_grant_idx out IW          index of the granted requester
// -----------------------------------------------------------------------------
module mbus_rr_arbiter
    import mbus_pkg::*;
#(
    parameter int unsigned DEVICE_NUM = 4,
    parameter int unsigned IW         = idx_w(DEVICE_NUM)
) (
    input  logic [DEVICE_NUM-1:0] i_req,
    input  logic [IW-1:0]         i_ptr,
    output logic [DEVICE_NUM-1:0] o_grant,
    output logic [IW-1:0]         o_grant_idx
);

    always_comb begin
        logic        w_found;
        int unsigned w_idx;
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int unsigned i = 0; i < DEVICE_NUM; i++) begin
            w_idx = (32'(i_ptr) + i) % DEVICE_NUM;
            if (!w_found && i_req[w_idx]) begin
                w_found              = 1'b1;
                o_grant[IW'(w_idx)]  = 1'b1;
                o_grant_idx          = IW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mbus_wr_arbiter.sv
// -----------------------------------------------------------------------------
// mbus_wr_arbiter
// Arbitrates DEVICE_NUM write requesters onto one DDR AXI-style write channel.
// Each grant issues one address phase followed by BURST_BEATS data beats.
//
// Optional feature (macro MBUS_WR_TIMEOUT_EN): a watchdog in the data phase.
// After TIMEOUT_CYCLES cycles without an accepted beat the remaining beats are
// flushed as zero words and o_err is set until reset. Without the macro o_err
// is tied low and the data phase waits indefinitely.
//
// Ports:
//   i_axi_aclk, i_rstn               clock, async active-low reset
//   i_mbus_wrq    [N]                per-device request
//   i_mbus_waddr  [N*CTRL_ADDR_WIDTH] packed start addresses, device 0 in LSBs
//   i_mbus_wdata  [N*DW]             packed write words, device 0 in LSBs
//   i_mbus_wready [N]                per-device word valid
//   o_mbus_wdata_rq                  data phase active, requester should stream
//   o_mbus_wbusy                     transaction in progress
//   o_mbus_wsel   [N]                one-hot grant
//   o_ddr_aw*                        DDR address channel
//   o_ddr_w*, i_ddr_wready           DDR data channel
//   o_err                            sticky watchdog flag
// -----------------------------------------------------------------------------
module mbus_wr_arbiter
    import mbus_pkg::*;
#(
    parameter int unsigned MEM_DQ_WIDTH    = 16,
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned BURST_LENGTH    = 8,
    parameter int unsigned DEVICE_NUM      = 4,
    parameter int unsigned BURST_BEATS     = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    localparam int unsigned DW             = MEM_DQ_WIDTH * BURST_LENGTH
) (
    input  logic                                i_axi_aclk,
    input  logic                                i_rstn,
    input  logic [DEVICE_NUM-1:0]               i_mbus_wrq,
    input  logic [DEVICE_NUM*CTRL_ADDR_WIDTH-1:0] i_mbus_waddr,
    input  logic [DEVICE_NUM*DW-1:0]            i_mbus_wdata,
    input  logic [DEVICE_NUM-1:0]               i_mbus_wready,
    output logic                                o_mbus_wdata_rq,
    output logic                                o_mbus_wbusy,
    output logic [DEVICE_NUM-1:0]               o_mbus_wsel,
    output logic [CTRL_ADDR_WIDTH-1:0]          o_ddr_awaddr,
    output logic [AWLEN_W-1:0]                  o_ddr_awlen,
    output logic                                o_ddr_awvalid,
    input  logic                                i_ddr_awready,
    output logic [DW-1:0]                       o_ddr_wdata,
    output logic                                o_ddr_wvalid,
    output logic                                o_ddr_wlast,
    input  logic                                i_ddr_wready,
    output logic                                o_err
);

    localparam int unsigned IW = idx_w(DEVICE_NUM);
    localparam int unsigned BW = $clog2(BURST_BEATS);
    localparam logic [BW-1:0]      LAST_BEAT = BW'(BURST_BEATS - 1);
    localparam logic [AWLEN_W-1:0] AWLEN_VAL = AWLEN_W'(BURST_BEATS - 1);

    mbus_state_e                r_state, w_state_nxt;
    logic [DEVICE_NUM-1:0]      r_sel;
    logic                       r_busy;
    logic                       r_wdata_rq;
    logic [IW-1:0]              r_idx;
    logic [IW-1:0]              r_ptr;
    logic [CTRL_ADDR_WIDTH-1:0] r_addr;
    logic [BW-1:0]              r_beat;

    logic [DEVICE_NUM-1:0]      w_grant;
    logic [IW-1:0]              w_grant_idx;
    logic [DW-1:0]              w_word;
    logic                       w_dev_ready;
    logic                       w_force;
    logic                       w_accept;
    logic                       w_last;

    mbus_rr_arbiter #(
        .DEVICE_NUM (DEVICE_NUM),
        .IW         (IW)
    ) u_rr (
        .i_req       (i_mbus_wrq),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_word      = i_mbus_wdata[r_idx*DW +: DW];
    assign w_dev_ready = i_mbus_wready[r_idx];
    assign w_last      = (r_beat == LAST_BEAT);

    // FSM next state and decoded outputs. Outputs are qualified by state so an
    // asynchronous reset forces every output low in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        o_ddr_awvalid = 1'b0;
        o_ddr_awlen   = '0;
        o_ddr_wvalid  = 1'b0;
        o_ddr_wdata   = '0;
        o_ddr_wlast   = 1'b0;
        w_accept      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|i_mbus_wrq) w_state_nxt = StAddr;
            end
            StAddr: begin
                o_ddr_awvalid = 1'b1;
                o_ddr_awlen   = AWLEN_VAL;
                if (i_ddr_awready) w_state_nxt = StData;
            end
            StData: begin
                o_ddr_wvalid = w_force | w_dev_ready;
                o_ddr_wdata  = w_force ? '0 : w_word;
                o_ddr_wlast  = w_last;
                w_accept     = o_ddr_wvalid & i_ddr_wready;
                if (w_accept && w_last) w_state_nxt = StDone;
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_wdata_rq <= 1'b0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (|i_mbus_wrq) begin
                        r_sel  <= w_grant;
                        r_busy <= 1'b1;
                        r_idx  <= w_grant_idx;
                        r_addr <= i_mbus_waddr[w_grant_idx*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
                        r_beat <= '0;
                    end
                end
                StAddr: begin
                    if (i_ddr_awready) r_wdata_rq <= 1'b1;
                end
                StData: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_beat     <= '0;
                            r_wdata_rq <= 1'b0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_sel  <= '0;
                    r_busy <= 1'b0;
                    // Next search starts just past the device we served.
                    r_ptr  <= (r_idx == IW'(DEVICE_NUM - 1)) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MBUS_WR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_force;
    logic          r_err;

    // Counts data-phase cycles since the last accepted beat; once the limit
    // is hit the burst is completed with zero words so the DDR side is not
    // left holding a partial burst.
    always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_to_cnt <= '0;
            r_force  <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state != StData) begin
            r_to_cnt <= '0;
            r_force  <= 1'b0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (!r_force) begin
            if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_force <= 1'b1;
                r_err   <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign w_force = r_force;
    assign o_err   = r_err;
`else
    // Watchdog compiled out; the limit parameter stays in the shared list.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_force          = 1'b0;
    assign o_err            = 1'b0;
`endif

    assign o_mbus_wsel     = r_sel;
    assign o_mbus_wbusy    = r_busy;
    assign o_mbus_wdata_rq = r_wdata_rq;
    assign o_ddr_awaddr    = r_addr;

endmodule

// File: tb/tb_mbus_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mbus_wr_arbiter
// Scoreboard bench: each directed scenario pushes its expected address phase
// and data beats into queues; a negedge monitor pops and compares whenever the
// DUT completes a handshake. A small requester model streams per-device words.
// -----------------------------------------------------------------------------
module tb_mbus_wr_arbiter;

    localparam int N     = 4;
    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int BEATS = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  sel;
    } aw_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } w_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      wrq;
    logic [N*AW-1:0]   waddr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      wready;
    logic              wdata_rq, wbusy;
    logic [N-1:0]      wsel;
    logic [AW-1:0]     awaddr;
    logic [7:0]        awlen;
    logic              awvalid, awready;
    logic [DW-1:0]     ddr_wdata;
    logic              ddr_wvalid, ddr_wlast, ddr_wready;
    logic              err;

    aw_t exp_aw[$];
    w_t  exp_w[$];
    int  checks = 0;
    int  errors = 0;
    int  aw_seen = 0;
    int  drv_cnt[N];
    bit  stall_en[N];

    mbus_wr_arbiter u_dut (
        .i_axi_aclk      (clk),
        .i_rstn          (rstn),
        .i_mbus_wrq      (wrq),
        .i_mbus_waddr    (waddr),
        .i_mbus_wdata    (wdata),
        .i_mbus_wready   (wready),
        .o_mbus_wdata_rq (wdata_rq),
        .o_mbus_wbusy    (wbusy),
        .o_mbus_wsel     (wsel),
        .o_ddr_awaddr    (awaddr),
        .o_ddr_awlen     (awlen),
        .o_ddr_awvalid   (awvalid),
        .i_ddr_awready   (awready),
        .o_ddr_wdata     (ddr_wdata),
        .o_ddr_wvalid    (ddr_wvalid),
        .o_ddr_wlast     (ddr_wlast),
        .i_ddr_wready    (ddr_wready),
        .o_err           (err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input int d, input int b);
        return {32'hC0DE_0000 + 32'(d), 64'h0123_4567_89AB_CDEF, 32'(b + 1)};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int d);
        return 28'h0010000 + 28'(d) * 28'h0001000;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Requester model: device d presents word_of(d, beats already accepted).
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) drv_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!wsel[i]) drv_cnt[i] <= 0;
                else if (ddr_wvalid && ddr_wready) drv_cnt[i] <= drv_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        wdata  = '0;
        wready = '0;
        for (int i = 0; i < N; i++) begin
            wdata[i*DW +: DW] = word_of(i, drv_cnt[i]);
            wready[i]         = !(stall_en[i] && drv_cnt[i] >= 5);
        end
    end

    // Monitor: handshakes are evaluated on the falling edge, values are stable.
    always @(negedge clk) begin
        if (rstn) begin
            if (awvalid && ddr_wvalid) chk("aw_w_overlap", 1, 0);
            if (awvalid && awready) begin
                aw_seen++;
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 1, 0);
                end else begin
                    aw_t e;
                    e = exp_aw.pop_front();
                    chk("awaddr", DW'(awaddr), DW'(e.addr));
                    chk("wsel", DW'(wsel), DW'(e.sel));
                    chk("awlen", DW'(awlen), DW'(BEATS - 1));
                    chk("wbusy", DW'(wbusy), 1);
                end
            end
            if (ddr_wvalid && ddr_wready) begin
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", 1, 0);
                end else begin
                    w_t e;
                    e = exp_w.pop_front();
                    chk("wdata", ddr_wdata, e.data);
                    chk("wlast", DW'(ddr_wlast), DW'(e.last));
                    chk("wdata_rq", DW'(wdata_rq), 1);
                end
            end
        end
    end

    task automatic push_txn(input int d, input logic [AW-1:0] a, input int zero_from);
        aw_t ea;
        w_t  ew;
        ea.addr = a;
        ea.sel  = N'(1) << d;
        exp_aw.push_back(ea);
        for (int b = 0; b < BEATS; b++) begin
            ew.data = (b >= zero_from) ? '0 : word_of(d, b);
            ew.last = (b == BEATS - 1);
            exp_w.push_back(ew);
        end
    endtask

    task automatic wait_aw(input int target, input int budget);
        int n;
        n = 0;
        while (aw_seen < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (aw_seen < target) chk("aw_wait_expired", 0, 1);
    endtask

    task automatic wait_idle(input int budget, input bit toggle);
        int n;
        bit done;
        n    = 0;
        done = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            if (toggle) ddr_wready = ~ddr_wready;
            n++;
            done = (exp_w.size() == 0) && (exp_aw.size() == 0) && !wbusy;
        end
        if (!done) begin
            chk("idle_wait_expired", 0, 1);
            exp_w.delete();
            exp_aw.delete();
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_awvalid"}, DW'(awvalid), 0);
        chk({tag, "_wvalid"}, DW'(ddr_wvalid), 0);
        chk({tag, "_wlast"}, DW'(ddr_wlast), 0);
        chk({tag, "_wdata"}, ddr_wdata, 0);
        chk({tag, "_wsel"}, DW'(wsel), 0);
        chk({tag, "_wbusy"}, DW'(wbusy), 0);
        chk({tag, "_wdata_rq"}, DW'(wdata_rq), 0);
        chk({tag, "_awaddr"}, DW'(awaddr), 0);
        chk({tag, "_awlen"}, DW'(awlen), 0);
        chk({tag, "_err"}, DW'(err), 0);
    endtask

    initial begin
        rstn       = 1'b0;
        wrq        = '0;
        waddr      = '0;
        awready    = 1'b1;
        ddr_wready = 1'b1;
        for (int i = 0; i < N; i++) stall_en[i] = 0;
        for (int i = 0; i < N; i++) waddr[i*AW +: AW] = addr_of(i);
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rstn = 1'b1;

        // All devices requesting: rotation 0,1,2,3,0 from reset.
        push_txn(0, addr_of(0), BEATS);
        push_txn(1, addr_of(1), BEATS);
        push_txn(2, addr_of(2), BEATS);
        push_txn(3, addr_of(3), BEATS);
        push_txn(0, addr_of(0), BEATS);
        wrq = 4'b1111;
        wait_aw(5, 600);
        wrq = '0;
        wait_idle(200, 0);

        // Single device 2 at 0x0001000.
        waddr[2*AW +: AW] = 28'h0001000;
        push_txn(2, 28'h0001000, BEATS);
        wrq = 4'b0100;
        wait_aw(aw_seen + 1, 50);
        wrq = '0;
        wait_idle(100, 0);
        waddr[2*AW +: AW] = addr_of(2);

        // DDR wready toggling every cycle, device 0.
        push_txn(0, addr_of(0), BEATS);
        wrq = 4'b0001;
        wait_aw(aw_seen + 1, 50);
        wrq = '0;
        wait_idle(200, 1);
        ddr_wready = 1'b1;

        // Request withdrawn while the address phase is stalled, device 1.
        awready = 1'b0;
        push_txn(1, addr_of(1), BEATS);
        wrq = 4'b0010;
        for (int n = 0; n < 20 && !awvalid; n++) begin
            @(posedge clk);
            #1;
        end
        chk("addr_phase_reached", DW'(awvalid), 1);
        wrq = '0;
        repeat (3) @(posedge clk);
        #1;
        awready = 1'b1;
        wait_idle(100, 0);

`ifdef MBUS_WR_TIMEOUT_EN
        // Device 2 stalls after five beats; watchdog flushes the rest as zero.
        stall_en[2] = 1;
        push_txn(2, addr_of(2), 5);
        wrq = 4'b0100;
        wait_aw(aw_seen + 1, 50);
        wrq = '0;
        wait_idle(2000, 0);
        stall_en[2] = 0;
        chk("err_after_timeout", DW'(err), 1);
`endif

        // Reset in the middle of a device 3 burst, after eight beats.
        push_txn(3, addr_of(3), BEATS);
        wrq = 4'b1000;
        wait_aw(aw_seen + 1, 50);
        wrq = '0;
        for (int n = 0; n < 50 && drv_cnt[3] < 8; n++) begin
            @(posedge clk);
            #1;
        end
        chk("beat8_reached", DW'(drv_cnt[3]), 8);
        rstn = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        exp_w.delete();
        exp_aw.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Pointer back at device 0 after reset.
        push_txn(0, addr_of(0), BEATS);
        wrq = 4'b1111;
        wait_aw(aw_seen + 1, 50);
        wrq = '0;
        wait_idle(100, 0);
        chk("err_final", DW'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
